// File: rtl/keypad_press_emulator.sv
// keypad_press_emulator: answers a 3x4 column-scanned keypad with row bits for queued virtual key presses
module keypad_press_emulator #(
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC = 1000,
  parameter int GAP_TICKS = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold,
  output logic       busy,
  output logic       pressing,
  output logic       done,
  output logic       err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PRESC);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);
  localparam logic [7:0] G_LAST = 8'(GAP_TICKS - 1);
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  state_t state, state_n;
  logic [3:0] fifo_key [FIFO_DEPTH];
  logic [7:0] fifo_hold [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] presc;
  logic [7:0] tick, hold_q, head_hold;
  logic [3:0] head_key;
  logic [1:0] row_q, col_q, head_r, head_c;
  logic full, has, bad, push, pop, clr, tick_end, press_end, gap_end, done_n, err_n;

  assign full = count == DEPTH_CNT;
  assign has = count != '0;
  assign cmd_ready = !full && !RESET;
  assign push = cmd_valid && cmd_ready;
  assign head_key = fifo_key[rd_ptr];
  assign head_hold = fifo_hold[rd_ptr];
  assign bad = head_key > 4'd11;
  assign head_r = head_key >= 4'd9 ? 2'd3 : head_key >= 4'd6 ? 2'd2 : head_key >= 4'd3 ? 2'd1 : 2'd0;
  assign head_c = 2'(head_key - 4'd3 * {2'b00, head_r});
  assign tick_end = presc == P_LAST;
  assign press_end = tick_end && tick == hold_q - 8'd1;
  assign gap_end = tick_end && tick == G_LAST;
  assign busy = state != IDLE || has;
  assign pressing = state == PRESS;

  // next state: pop the head from IDLE or at the end of a gap, range-checking the key
  always_comb begin
    state_n = state;
    pop = 1'b0;
    clr = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (has) begin
        pop = 1'b1;
        err_n = bad;
        clr = !bad;
        state_n = bad ? IDLE : PRESS;
      end
      PRESS: if (press_end) begin
        clr = 1'b1;
        state_n = GAP;
      end
      GAP: if (gap_end) begin
        done_n = 1'b1;
        pop = has;
        err_n = has && bad;
        clr = has && !bad;
        state_n = (has && !bad) ? PRESS : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end

  // command storage; push is already blocked during reset through cmd_ready
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_key[wr_ptr] <= cmd_key;
      fifo_hold[wr_ptr] <= cmd_hold;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // popped-key latch, tick prescaler restarted on each phase entry, registered row return and pulses
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_q <= 8'd1;
      row_q <= '0;
      col_q <= '0;
      presc <= '0;
      tick <= '0;
      key_row <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      if (pop) begin
        hold_q <= head_hold == 8'd0 ? 8'd1 : head_hold;
        row_q <= head_r;
        col_q <= head_c;
      end
      presc <= (clr || tick_end) ? '0 : presc + 1'b1;
      tick <= clr ? 8'd0 : tick_end ? tick + 8'd1 : tick;
      key_row <= (state == PRESS && key_col[col_q]) ? 4'b0001 << row_q : 4'b0000;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_keypad_press_emulator.sv
// tb_keypad_press_emulator: scoreboard bench for the keypad press emulator
module tb_keypad_press_emulator;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [2:0] key_col = 3'b000;
  logic [3:0] key_row;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_key = 4'd0;
  logic [7:0] cmd_hold = 8'd0;
  logic busy, pressing, done, err;
  int total = 0;
  int bad = 0;
  typedef struct packed {logic is_err; logic [3:0] row; logic [15:0] width;} rec_t;
  rec_t exp_q[$];
  rec_t obs_q[$];
  int mon_w = 0;
  logic [3:0] mon_row = 4'b0000;

  keypad_press_emulator #(.FIFO_DEPTH(4), .PRESC(4), .GAP_TICKS(2)) dut (
    .CLK(CLK), .RESET(RESET), .key_col(key_col), .key_row(key_row),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
    .busy(busy), .pressing(pressing), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // collects one record per finished press (width, rows seen) and per err pulse
  always @(negedge CLK) begin
    if (RESET) begin
      mon_w = 0;
      mon_row = 4'b0000;
    end else begin
      if (done) begin
        obs_q.push_back('{1'b0, mon_row, 16'(mon_w)});
        mon_w = 0;
        mon_row = 4'b0000;
      end
      if (err) obs_q.push_back('{1'b1, 4'b0000, 16'd0});
      if (pressing) mon_w++;
      mon_row |= key_row;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic push_cmd(input logic [3:0] k, input logic [7:0] h);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_key = k;
    cmd_hold = h;
    @(negedge CLK);
    while (!cmd_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout key=%0d cmd_ready stayed 0 want 1", k);
    end
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++; if (key_row !== 4'b0000) begin bad++; $display("FAIL rst_key_row got=%b want=0000", key_row); end
    total++; if (pressing !== 1'b0) begin bad++; $display("FAIL rst_pressing got=%b want=0", pressing); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_pulses got done=%b err=%b want 0 0", done, err); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", cmd_ready); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single;
    rec_t e, o;
    key_col = 3'b010;
    exp_q.push_back('{1'b0, 4'b0010, 16'd12});
    push_cmd(4'd4, 8'd3);
    for (int i = 0; i < 24; i++) begin
      logic ep, ed, eb;
      logic [3:0] er;
      @(negedge CLK);
      ep = i >= 1 && i <= 12;
      er = (i >= 2 && i <= 13) ? 4'b0010 : 4'b0000;
      ed = i == 21;
      eb = i <= 20;
      total++; if (pressing !== ep) begin bad++; $display("FAIL single_pressing cyc=%0d got=%b want=%b", i, pressing, ep); end
      total++; if (key_row !== er) begin bad++; $display("FAIL single_row cyc=%0d got=%b want=%b", i, key_row, er); end
      total++; if (done !== ed) begin bad++; $display("FAIL single_done cyc=%0d got=%b want=%b", i, done, ed); end
      total++; if (busy !== eb) begin bad++; $display("FAIL single_busy cyc=%0d got=%b want=%b", i, busy, eb); end
      @(posedge CLK);
      #1;
    end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL single_sb got err=%b row=%b w=%0d want err=%b row=%b w=%0d", o.is_err, o.row, o.width, e.is_err, e.row, e.width); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_scan;
    rec_t e, o;
    logic [2:0] pat [3] = '{3'b001, 3'b010, 3'b100};
    logic prev_p = 1'b0;
    logic [2:0] prev_c = 3'b000;
    int hits = 0;
    exp_q.push_back('{1'b0, 4'b1000, 16'd8});
    push_cmd(4'd11, 8'd2);
    for (int i = 0; i < 24; i++) begin
      logic [3:0] er;
      key_col = pat[i % 3];
      @(negedge CLK);
      er = (prev_p && prev_c[2]) ? 4'b1000 : 4'b0000;
      total++; if (key_row !== er) begin bad++; $display("FAIL scan_row cyc=%0d got=%b want=%b", i, key_row, er); end
      if (key_row == 4'b1000) hits++;
      prev_p = pressing;
      prev_c = key_col;
      @(posedge CLK);
      #1;
    end
    total++; if (hits == 0) begin bad++; $display("FAIL scan_hits got=0 want>0"); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL scan_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL scan_sb got err=%b row=%b w=%0d want err=%b row=%b w=%0d", o.is_err, o.row, o.width, e.is_err, e.row, e.width); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    rec_t e, o;
    logic [3:0] keys [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    logic [3:0] rows [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    int dn = 0;
    int n = 0;
    key_col = 3'b111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{1'b0, rows[i], 16'd4});
      push_cmd(keys[i], 8'd1);
    end
    @(negedge CLK);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fifo_full_ready got=%b want=0", cmd_ready); end
    while (dn < 5 && n < 300) begin
      if (done) begin
        dn++;
        if (dn < 5) begin
          total++; if (pressing !== 1'b1) begin bad++; $display("FAIL fifo_chain done#%0d pressing got=%b want=1", dn, pressing); end
        end else begin
          total++; if (busy !== 1'b0) begin bad++; $display("FAIL fifo_final_busy got=%b want=0", busy); end
        end
      end
      if (dn < 5) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fifo_busy cyc=%0d got=%b want=1", n, busy); end
      end
      n++;
      @(negedge CLK);
    end
    total++; if (dn != 5) begin bad++; $display("FAIL fifo_done_count got=%0d want=5", dn); end
    @(posedge CLK);
    #1;
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL fifo_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL fifo_sb got err=%b row=%b w=%0d want err=%b row=%b w=%0d", o.is_err, o.row, o.width, e.is_err, e.row, e.width); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_edges;
    rec_t e, o;
    key_col = 3'b111;
    exp_q.push_back('{1'b1, 4'b0000, 16'd0});
    exp_q.push_back('{1'b0, 4'b0001, 16'd4});
    push_cmd(4'd12, 8'd1);
    push_cmd(4'd0, 8'd0);
    @(negedge CLK);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL edge_err got=%b want=1", err); end
    total++; if (pressing !== 1'b0) begin bad++; $display("FAIL edge_bad_pressing got=%b want=0", pressing); end
    @(negedge CLK);
    total++; if (pressing !== 1'b1) begin bad++; $display("FAIL edge_next_pop got=%b want=1", pressing); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL edge_err_width got=%b want=0", err); end
    repeat (20) @(negedge CLK);
    @(posedge CLK);
    #1;
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL edge_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL edge_sb got err=%b row=%b w=%0d want err=%b row=%b w=%0d", o.is_err, o.row, o.width, e.is_err, e.row, e.width); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_press;
    int stray = 0;
    key_col = 3'b111;
    push_cmd(4'd6, 8'd3);
    push_cmd(4'd7, 8'd1);
    push_cmd(4'd8, 8'd1);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    total++; if (key_row !== 4'b0100) begin bad++; $display("FAIL mid_row_before got=%b want=0100", key_row); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_reset got=%b want=0", cmd_ready); end
    @(negedge CLK);
    total++; if (key_row !== 4'b0000) begin bad++; $display("FAIL mid_row got=%b want=0000", key_row); end
    total++; if (pressing !== 1'b0) begin bad++; $display("FAIL mid_pressing got=%b want=0", pressing); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b want=0", cmd_ready); end
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b want=1", cmd_ready); end
    for (int i = 0; i < 60; i++) begin
      if (pressing || busy || done || err || key_row != 4'b0000) stray++;
      @(negedge CLK);
    end
    total++; if (stray != 0) begin bad++; $display("FAIL mid_residual active_cycles got=%0d want=0", stray); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_residual_events got=%0d want=0", obs_q.size()); end
    exp_q.delete();
    obs_q.delete();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_back_to_back();
    test_edges();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
